gshare_bht: RTL and testbench
=============================

Name: gshare_bht

Overview:
- Branch history table feeding per-branch saturating-counter predictions to fetch, indexed gshare-style.
- Index is PC bits XOR a global history register (GHR).
- Sits between fetch (lookup port) and branch resolution in execute (update port).
- Holds 2^IDX_W N-bit saturating counters internally; GHR is non-speculative.

Parameters:
N, 2, counter width in bits; prediction is taken when counter >= 2^(N-1)
IDX_W, 6, table index width; table depth is 2^IDX_W
HIST_W, 6, GHR width; legal range 1..IDX_W
PC_W, 32, PC width; must be >= IDX_W+2

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
lookup_valid  input  1  fetch requests a prediction this cycle
lookup_pc  input  PC_W  PC of the fetched branch
pred_valid  output  1  prediction valid; registered
pred_taken  output  1  predicted direction
pred_idx  output  IDX_W  table index used; fetch carries it to resolve
update_valid  input  1  resolved conditional branch this cycle
update_idx  input  IDX_W  pred_idx returned from lookup
update_taken  input  1  actual direction
update_pred  input  1  direction originally predicted
stat_updates  output  32  resolved-branch count (optional feature)
stat_mispred  output  32  misprediction count (optional feature)

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - Reset has priority over everything.
  - In one cycle: all table entries <= 0 (strongly not-taken), GHR <= 0, pred_valid/pred_taken/pred_idx <= 0, stats <= 0.
  - Lookups and updates presented in a reset cycle are dropped.
- Index function:
  - idx = lookup_pc[IDX_W+1:2] XOR zero-extend(GHR) to IDX_W bits.
  - GHR[0] is the most recent outcome.
- Lookup latency is 1 cycle.
  - If lookup_valid is high at edge k, then after edge k: pred_valid=1, pred_idx=idx, pred_taken = (entry >= 2^(N-1)).
  - If lookup_valid is low, pred_valid=0; pred_taken and pred_idx hold their previous values.
  - No stall/backpressure; one lookup per cycle.
- Update, when update_valid is high:
  - update_taken=1: entry[update_idx] += 1, saturating at 2^N-1.
  - update_taken=0: entry[update_idx] -= 1, saturating at 0.
  - GHR <= {GHR[HIST_W-2:0], update_taken}; for HIST_W=1, GHR <= update_taken.
  - Effects are visible after the edge.
- Simultaneous lookup and update in the same cycle:
  - The lookup index uses the pre-update GHR.
  - If the lookup index equals update_idx, the prediction uses the post-update counter value (write-first bypass).
  - Other indices read the stored value.
- Width rules:
  - Counter arithmetic is done in N bits with explicit saturation checks; the counter never wraps.
  - GHR bits above HIST_W do not exist; unused index XOR bits pass PC bits through.
- update_idx is taken as given; no range check is needed, since the width guarantees it is in range.

Optional Feature:
BHT_STATS_EN
- Defined:
  - stat_updates increments on every update_valid.
  - stat_mispred increments when update_valid && (update_taken != update_pred).
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter registers are built.

Test Plan:
All scenarios use the default parameters.
1. Reset, then lookup_pc=0x40 -> next cycle pred_valid=1, pred_idx=0x10, pred_taken=0; the following idle cycle gives pred_valid=0.
2. Two updates (idx=0x10, taken=1) -> GHR=0b000011.
   - lookup_pc=0x40 -> pred_idx=0x13, pred_taken=0.
   - lookup_pc=0x4C -> pred_idx=0x10, pred_taken=1.
3. Saturation on idx=0x05:
   - 5 taken updates -> counter 3, pred 1.
   - 1 not-taken -> counter 2, pred 1.
   - 2 more not-taken -> counter 0, pred 0.
   - 2 further not-taken -> counter stays 0, no wrap to 3.
4. Bypass: entry 0x10 at 1, GHR=0. In the same cycle, update(idx=0x10, taken=1) and lookup_pc=0x40 -> pred_idx=0x10, pred_taken=1, entry=2.
5. Reset mid-operation: train entry 0x10 to 3, GHR nonzero.
   - Assert reset for 1 cycle with lookup_valid=1 and update_valid=1 -> next cycle pred_valid=0.
   - A subsequent lookup_pc=0x40 gives pred_idx=0x10, pred_taken=0.
6. With BHT_STATS_EN: 10 updates, 3 with update_taken!=update_pred -> stat_updates=10, stat_mispred=3. Without the macro, both read 0.

Source files
------------

// File: rtl/gshare_bht.sv
// gshare_bht: gshare-indexed table of N-bit saturating counters predicting branch direction.
// The index is lookup_pc[IDX_W+1:2] XOR a non-speculative global history register.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   lookup_valid, lookup_pc          fetch-side prediction request
//   pred_valid, pred_taken, pred_idx registered prediction (1-cycle latency)
//   update_valid, update_idx,        resolved conditional branch from execute
//   update_taken, update_pred
//   stat_updates, stat_mispred       resolved / mispredicted counts
// Optional feature macro: BHT_STATS_EN builds the statistics counters; without it
// both stat ports are tied to 0.
module gshare_bht #(
  parameter int unsigned N      = 2,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic              update_taken,
  input  logic              update_pred,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispred
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [N-1:0] CNT_MAX = '1;

  logic [N-1:0]      cnt_q [DEPTH];
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_next_c;
  logic [IDX_W-1:0]  idx_c;
  logic [N-1:0]      upd_old_c;
  logic [N-1:0]      upd_new_c;
  logic [N-1:0]      rd_c;

  // Lookup index uses the pre-update history.
  assign idx_c = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

  // Saturating counter step for the entry being updated.
  always_comb begin
    upd_old_c = cnt_q[update_idx];
    upd_new_c = upd_old_c;
    if (update_taken) begin
      if (upd_old_c != CNT_MAX) upd_new_c = upd_old_c + N'(1);
    end else begin
      if (upd_old_c != '0) upd_new_c = upd_old_c - N'(1);
    end
  end

  // Write-first bypass when lookup and update hit the same entry.
  always_comb begin
    rd_c = cnt_q[idx_c];
    if (update_valid && (update_idx == idx_c)) rd_c = upd_new_c;
  end

  // History shift, newest outcome in bit 0.
  generate
    if (HIST_W == 1) begin : g_ghr1
      assign ghr_next_c = update_taken;
    end else begin : g_ghrn
      assign ghr_next_c = {ghr_q[HIST_W-2:0], update_taken};
    end
  endgenerate

  // Table, history and prediction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt_q[IDX_W'(i)] <= '0;
      ghr_q      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      if (update_valid) begin
        cnt_q[update_idx] <= upd_new_c;
        ghr_q             <= ghr_next_c;
      end
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= rd_c[N-1]; // entry >= 2^(N-1) iff MSB set
        pred_idx   <= idx_c;
      end
    end
  end

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc;
  generate
    if (PC_W > IDX_W + 2) begin : g_pc_hi
      assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
    end else begin : g_pc_lo
      assign unused_pc = ^lookup_pc[1:0];
    end
  endgenerate

`ifdef BHT_STATS_EN
  // Saturating resolved/mispredict counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (update_valid) begin
      if (stat_updates != 32'hFFFF_FFFF) stat_updates <= stat_updates + 32'(1);
      if ((update_taken != update_pred) && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'(1);
    end
  end
`else
  assign stat_updates = '0;
  assign stat_mispred = '0;
  logic unused_pred;
  assign unused_pred = update_pred;
`endif

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed vector table plus a hand-written statistics sequence for gshare_bht
// with default parameters (N=2, IDX_W=6, HIST_W=6, PC_W=32).
module tb_gshare_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        update_valid;
  logic [5:0]  update_idx;
  logic        update_taken;
  logic        update_pred;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_bht dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_idx     (pred_idx),
    .update_valid (update_valid),
    .update_idx   (update_idx),
    .update_taken (update_taken),
    .update_pred  (update_pred),
    .stat_updates (stat_updates),
    .stat_mispred (stat_mispred)
  );

  typedef struct {
    logic        rst;
    logic        lv;
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  uidx;
    logic        ut;
    logic        up;
    logic        e_pv;
    logic        e_pt;
    logic [5:0]  e_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic lv, input logic [31:0] pc,
                     input logic uv, input logic [5:0] uidx, input logic ut,
                     input logic e_pv, input logic e_pt, input logic [5:0] e_idx);
    vec_t v;
    v.rst = rst; v.lv = lv; v.pc = pc; v.uv = uv; v.uidx = uidx; v.ut = ut; v.up = 1'b0;
    v.e_pv = e_pv; v.e_pt = e_pt; v.e_idx = e_idx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic lv, input logic [31:0] pc,
                       input logic uv, input logic [5:0] uidx, input logic ut, input logic up);
    @(negedge clk);
    reset = rst; lookup_valid = lv; lookup_pc = pc;
    update_valid = uv; update_idx = uidx; update_taken = ut; update_pred = up;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_idx = '0; update_taken = 1'b0; update_pred = 1'b0;

    //  rst lv  pc      uv  uidx  ut   pv  pt  idx
    add(1, 0, 32'h00, 0, 6'h00, 0,   0, 0, 6'h00); // reset
    add(0, 1, 32'h40, 0, 6'h00, 0,   1, 0, 6'h10); // first lookup
    add(0, 0, 32'h00, 0, 6'h00, 0,   0, 0, 6'h10); // idle: pv drops, hold
    add(0, 0, 32'h00, 1, 6'h10, 1,   0, 0, 6'h10); // entry10=1, ghr=1
    add(0, 0, 32'h00, 1, 6'h10, 1,   0, 0, 6'h10); // entry10=2, ghr=3
    add(0, 1, 32'h40, 0, 6'h00, 0,   1, 0, 6'h13); // 0x10^3
    add(0, 1, 32'h4C, 0, 6'h00, 0,   1, 1, 6'h10); // 0x13^3
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h00, 1, 6'h05, 1, 0, 1, 6'h10); // entry5 -> 3, ghr=3F
    add(0, 1, 32'hE8, 0, 6'h00, 0,   1, 1, 6'h05); // 0x3A^0x3F
    add(0, 0, 32'h00, 1, 6'h05, 0,   0, 1, 6'h05); // entry5=2, ghr=3E
    add(0, 1, 32'hEC, 0, 6'h00, 0,   1, 1, 6'h05); // 0x3B^0x3E
    add(0, 0, 32'h00, 1, 6'h05, 0,   0, 1, 6'h05); // entry5=1
    add(0, 0, 32'h00, 1, 6'h05, 0,   0, 1, 6'h05); // entry5=0, ghr=38
    add(0, 1, 32'hF4, 0, 6'h00, 0,   1, 0, 6'h05); // 0x3D^0x38
    add(0, 0, 32'h00, 1, 6'h05, 0,   0, 0, 6'h05); // stays 0
    add(0, 0, 32'h00, 1, 6'h05, 0,   0, 0, 6'h05); // stays 0, ghr=20
    add(0, 1, 32'h94, 0, 6'h00, 0,   1, 0, 6'h05); // 0x25^0x20, no wrap
    add(0, 0, 32'h00, 1, 6'h10, 0,   0, 0, 6'h05); // entry10=1, ghr=0
    add(0, 1, 32'h40, 1, 6'h10, 1,   1, 1, 6'h10); // bypass: sees 2
    add(0, 1, 32'h44, 0, 6'h00, 0,   1, 1, 6'h10); // ghr=1, 0x11^1
    add(0, 0, 32'h00, 1, 6'h10, 1,   0, 1, 6'h10); // entry10=3, ghr=3
    add(1, 1, 32'h40, 1, 6'h10, 1,   0, 0, 6'h00); // reset wins
    add(0, 1, 32'h40, 0, 6'h00, 0,   1, 0, 6'h10); // cleared table/ghr

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lv, vecs[i].pc, vecs[i].uv, vecs[i].uidx, vecs[i].ut, vecs[i].up);
      check($sformatf("v%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_pv));
      check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
      check($sformatf("v%0d pred_idx", i),   32'(pred_idx),   32'(vecs[i].e_idx));
    end

    // Statistics: cleared by the reset above, then 10 updates with 3 mispredicts.
    check("stat_updates after reset", stat_updates, 32'd0);
    check("stat_mispred after reset", stat_mispred, 32'd0);
    for (int i = 0; i < 10; i++) begin
      logic t;
      t = 1'(i % 2);
      drive(0, 0, 32'h0, 1, 6'h20, t, (i == 1 || i == 4 || i == 8) ? ~t : t);
    end
    drive(0, 0, 32'h0, 0, 6'h00, 0, 0);
`ifdef BHT_STATS_EN
    check("stat_updates", stat_updates, 32'd10);
    check("stat_mispred", stat_mispred, 32'd3);
`else
    check("stat_updates", stat_updates, 32'd0);
    check("stat_mispred", stat_mispred, 32'd0);
`endif
    // Update with update_valid low must not count.
    drive(0, 0, 32'h0, 0, 6'h20, 1, 0);
`ifdef BHT_STATS_EN
    check("stat_updates idle", stat_updates, 32'd10);
`else
    check("stat_updates idle", stat_updates, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
